// File: rtl/tpu_result_drain_pkg.sv
// Package shared by the result-drain datapath.
// Contents: drain FSM state encoding, default widths, the configuration field
// width, and helper functions for the signed saturation bounds.
package tpu_result_drain_pkg;

  localparam int DEF_ACC_WIDTH = 32;
  localparam int DEF_OUT_WIDTH = 8;
  localparam int SHIFT_WIDTH   = 5;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } drain_state_e;

  // Largest value representable in a signed field of width w.
  function automatic int sat_max_f(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

  // Most negative value representable in a signed field of width w.
  function automatic int sat_min_f(input int w);
    return -(2 ** (w - 1));
  endfunction

endpackage

// File: rtl/tpu_result_drain_requant.sv
// Combinational requantizer: x (signed ACC_WIDTH) -> y (signed OUT_WIDTH).
// Steps: round-half-up arithmetic right shift, optional ReLU, then saturation.
// All math is carried one bit wider than the accumulator, so adding the
// rounding constant can never overflow.
// Ports:
//   x_i     signed accumulator value
//   shift_i right-shift amount 0..31 (0 = pass through, no rounding)
//   relu_i  clamp negative results to zero
//   y_o     saturated signed result
module tpu_result_drain_requant
  import tpu_result_drain_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]   x_i,
  input  logic        [SHIFT_WIDTH-1:0] shift_i,
  input  logic                          relu_i,
  output logic signed [OUT_WIDTH-1:0]   y_o
);

  localparam int EW = ACC_WIDTH + 1;
  localparam logic signed [EW-1:0] SAT_MAX = EW'(sat_max_f(OUT_WIDTH));
  localparam logic signed [EW-1:0] SAT_MIN = EW'(sat_min_f(OUT_WIDTH));
  localparam logic signed [EW-1:0] ONE_E   = {{(EW-1){1'b0}}, 1'b1};

  logic signed [EW-1:0] xe_s;
  logic signed [EW-1:0] rnd_s;
  logic signed [EW-1:0] sum_s;
  logic signed [EW-1:0] sh_s;
  logic signed [EW-1:0] rl_s;

  // Round, shift, rectify and saturate one element.
  always_comb begin
    xe_s  = {x_i[ACC_WIDTH-1], x_i};
    rnd_s = ONE_E << (shift_i - 5'd1);
    sum_s = xe_s + rnd_s;
    if (shift_i == 5'd0) begin
      sh_s = xe_s;
    end else begin
      sh_s = sum_s >>> shift_i;
    end
    if (relu_i && (sh_s < $signed({EW{1'b0}}))) begin
      rl_s = {EW{1'b0}};
    end else begin
      rl_s = sh_s;
    end
    if (rl_s > SAT_MAX) begin
      y_o = SAT_MAX[OUT_WIDTH-1:0];
    end else if (rl_s < SAT_MIN) begin
      y_o = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      y_o = rl_s[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/tpu_result_drain.sv
// Result drain: snapshots the SIZE x SIZE accumulator tile on capture,
// requantizes each element and streams them out in row-major order over a
// valid/ready handshake, sustaining one element per cycle.
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset with synchronised release
//   capture         1-cycle pulse; takes the snapshot when idle
//   acc_flat        element (r,c) at [(r*SIZE+c)*ACC_WIDTH +: ACC_WIDTH]
//   shift_amt       requant shift, latched at capture
//   relu_en         requant ReLU enable, latched at capture
//   clear_overrun   clears the sticky overrun flag
//   out_valid/out_ready/out_data/out_index/out_last  output stream
//   busy            high while streaming
//   drain_done      1-cycle pulse after the final handshake
//   overrun         sticky: capture arrived while streaming
module tpu_result_drain
  import tpu_result_drain_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int IDX_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          capture,
  input  logic [SIZE*SIZE*ACC_WIDTH-1:0] acc_flat,
  input  logic [SHIFT_WIDTH-1:0]        shift_amt,
  input  logic                          relu_en,
  input  logic                          clear_overrun,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic [IDX_WIDTH-1:0]          out_index,
  output logic                          out_last,
  output logic                          busy,
  output logic                          drain_done,
  output logic                          overrun
);

  localparam int NUM = SIZE * SIZE;
  localparam int SNAP_W = NUM * ACC_WIDTH;
  localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM - 1);

  drain_state_e                 state_q, state_d;
  logic [SNAP_W-1:0]            snap_q, snap_d;
  logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
  logic                         relu_q, relu_d;
  logic [IDX_WIDTH-1:0]         idx_q, idx_d;
  logic                         valid_q, valid_d;
  logic [OUT_WIDTH-1:0]         data_q, data_d;
  logic                         last_q, last_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         overrun_q, overrun_d;
  logic [1:0]                   rst_sync_q;

  logic [IDX_WIDTH-1:0]         next_idx_s;
  logic signed [ACC_WIDTH-1:0]  rq_x_s;
  logic [SHIFT_WIDTH-1:0]       rq_shift_s;
  logic                         rq_relu_s;
  logic signed [OUT_WIDTH-1:0]  rq_y_s;
  logic                         run_s;
  logic                         handshake_s;

  assign run_s       = rst_sync_q[1];
  assign next_idx_s  = idx_q + IDX_ONE;
  assign handshake_s = valid_q && out_ready;

  // Requantizer source: live inputs for element 0 while idle, otherwise the
  // snapshot element that the next handshake will present.
  always_comb begin
    if (state_q == ST_IDLE) begin
      rq_x_s     = acc_flat[ACC_WIDTH-1:0];
      rq_shift_s = shift_amt;
      rq_relu_s  = relu_en;
    end else begin
      rq_x_s     = snap_q[int'(next_idx_s) * ACC_WIDTH +: ACC_WIDTH];
      rq_shift_s = shift_q;
      rq_relu_s  = relu_q;
    end
  end

  tpu_result_drain_requant #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_requant (
    .x_i     (rq_x_s),
    .shift_i (rq_shift_s),
    .relu_i  (rq_relu_s),
    .y_o     (rq_y_s)
  );

  // Next-state logic: FSM, snapshot, output registers and overrun flag.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (clear_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          snap_d  = acc_flat;
          shift_d = shift_amt;
          relu_d  = relu_en;
          idx_d   = {IDX_WIDTH{1'b0}};
          data_d  = rq_y_s;
          last_d  = (NUM == 1);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        // Setting wins over a simultaneous clear.
        if (capture) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_d;
        end
        if (handshake_s && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (handshake_s) begin
          idx_d  = next_idx_s;
          data_d = rq_y_s;
          last_d = (next_idx_s == IDX_LAST);
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Hold everything in its reset value until reset release is synchronised.
    if (!run_s) begin
      state_d   = ST_IDLE;
      snap_d    = {SNAP_W{1'b0}};
      shift_d   = {SHIFT_WIDTH{1'b0}};
      relu_d    = 1'b0;
      idx_d     = {IDX_WIDTH{1'b0}};
      valid_d   = 1'b0;
      data_d    = {OUT_WIDTH{1'b0}};
      last_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end else begin
      done_d = done_d;
    end
  end

  // Reset release synchroniser: assertion is immediate, release takes two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      snap_q    <= {SNAP_W{1'b0}};
      shift_q   <= {SHIFT_WIDTH{1'b0}};
      relu_q    <= 1'b0;
      idx_q     <= {IDX_WIDTH{1'b0}};
      valid_q   <= 1'b0;
      data_q    <= {OUT_WIDTH{1'b0}};
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_index  = idx_q;
  assign out_last   = last_q;
  assign busy       = busy_q;
  assign drain_done = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_tpu_result_drain.sv
// Scoreboard bench for tpu_result_drain: stimulus pushes expected elements,
// an independent negedge monitor pops and compares on every handshake.
module tb_tpu_result_drain;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         capture;
  logic [511:0] acc_flat;
  logic [4:0]   shift_amt;
  logic         relu_en;
  logic         clear_overrun;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [3:0]   out_index;
  logic         out_last;
  logic         busy;
  logic         drain_done;
  logic         overrun;

  tpu_result_drain dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .capture       (capture),
    .acc_flat      (acc_flat),
    .shift_amt     (shift_amt),
    .relu_en       (relu_en),
    .clear_overrun (clear_overrun),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_index     (out_index),
    .out_last      (out_last),
    .busy          (busy),
    .drain_done    (drain_done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   tb_acc[16];
  int   tb_exp[16];

  logic       expect_done = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] st_data;
  logic [3:0] st_idx;
  logic       st_last;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compares every handshake against the scoreboard, stall stability
  // and the drain_done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall  = 1'b0;
      expect_done = 1'b0;
    end else begin
      chk("drain_done", drain_done, expect_done);
      expect_done = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, st_data);
        chk("stall_index", out_index, st_idx);
        chk("stall_last", out_last, st_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected index=%0d data=%0d required none", out_index, $signed(out_data));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_data", $signed(out_data), $signed(e.data));
          chk("sb_index", out_index, e.idx);
          chk("sb_last", out_last, e.last);
          if (out_last) expect_done = 1'b1;
        end
        prev_stall = 1'b0;
      end else if (out_valid) begin
        prev_stall = 1'b1;
        st_data = out_data;
        st_idx  = out_index;
        st_last = out_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic issue_tile(input logic [4:0] sh, input logic rl);
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      exp_t e;
      acc_flat[k*32 +: 32] = tb_acc[k];
      e.data = 8'(tb_exp[k]);
      e.idx  = 4'(k);
      e.last = (k == 15);
      exp_q.push_back(e);
    end
    shift_amt = sh;
    relu_en   = rl;
    capture   = 1'b1;
    @(posedge clk);
    #1;
    capture = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy || expect_done) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, (n < budget), 1);
  endtask

  task automatic find_index(input string name, input logic [3:0] ix);
    int n = 0;
    while (!(out_valid && out_index == ix) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, (n < 60), 1);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < 16; k++) begin
      tb_acc[k] = k * 16;
      tb_exp[k] = k;
    end
  endtask

  initial begin
    int vcnt;
    rst_n = 1'b0;
    capture = 1'b0;
    acc_flat = '0;
    shift_amt = 5'd0;
    relu_en = 1'b0;
    clear_overrun = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // 1: reset state, idle with toggling ready
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 out_ready = ~out_ready;
      @(negedge clk);
      vcnt += int'(out_valid);
    end
    chk("idle_no_output", vcnt, 0);
    out_ready = 1'b1;

    // 2: ramp, full throughput
    set_ramp();
    issue_tile(5'd4, 1'b0);
    chk("busy_after_capture", busy, 1);
    vcnt = 0;
    repeat (16) begin
      @(negedge clk);
      vcnt += int'(out_valid);
    end
    chk("ramp_valid_cycles", vcnt, 16);
    wait_idle("ramp_timeout", 50);

    // 3: rounding and saturation
    tb_acc = '{5, 6, -6, -7, 1000, -1000, 0, 1, 2, 3, -1, -2, -3, 508, -514, -2};
    tb_exp = '{1, 2, -1, -2, 127, -128, 0, 0, 1, 1, 0, 0, -1, 127, -128, 0};
    issue_tile(5'd2, 1'b0);
    wait_idle("round_timeout", 50);
    tb_acc = '{32'h7FFFFFFF, 32'h80000000, 0, 1, -1, 127, 128, -128,
               -129, 100, -100, 50, -50, 126, -127, 2};
    tb_exp = '{127, -128, 0, 1, -1, 127, 127, -128,
               -128, 100, -100, 50, -50, 126, -127, 2};
    issue_tile(5'd0, 1'b0);
    wait_idle("sat_timeout", 50);

    // 4: ReLU and maximum shift
    tb_acc = '{-5, 7, -200, 0, 1, -1, 127, 128, 300, -300, 10, -10, 20, -20, 64, -64};
    tb_exp = '{0, 7, 0, 0, 1, 0, 127, 127, 127, 0, 10, 0, 20, 0, 64, 0};
    issue_tile(5'd0, 1'b1);
    wait_idle("relu_timeout", 50);
    tb_acc = '{32'h7FFFFFFF, 0, 32'h80000000, 32'h40000000, 32'h3FFFFFFF,
               32'hFFFFFFFF, 32'hC0000000, 32'hBFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0};
    tb_exp = '{1, 0, -1, 1, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0};
    issue_tile(5'd31, 1'b0);
    wait_idle("shift31_timeout", 50);

    // 5: random backpressure; inputs scrambled mid-stream
    for (int k = 0; k < 16; k++) begin
      tb_acc[k] = k * 32 - 256;
      tb_exp[k] = k - 8;
    end
    issue_tile(5'd5, 1'b0);
    begin
      int n = 0;
      while ((exp_q.size() != 0 || busy || expect_done) && n < 600) begin
        @(posedge clk);
        #1 out_ready = 1'($urandom_range(0, 1));
        if (n == 3) begin
          acc_flat  = {16{32'h12345678}};
          shift_amt = 5'd0;
          relu_en   = 1'b1;
        end
        n++;
      end
      chk("bp_timeout", (n < 600), 1);
    end
    out_ready = 1'b1;

    // 6: overrun, set-wins, reset mid-stream
    set_ramp();
    issue_tile(5'd4, 1'b0);
    find_index("find7", 4'd7);
    #2;
    acc_flat = {16{32'h0000_7F00}};
    capture = 1'b1;
    @(posedge clk);
    #1 capture = 1'b0;
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    wait_idle("overrun_tile_timeout", 50);
    chk("overrun_sticky", overrun, 1);
    @(posedge clk);
    #1 clear_overrun = 1'b1;
    @(posedge clk);
    #1 clear_overrun = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", overrun, 0);

    issue_tile(5'd4, 1'b0);
    find_index("find3", 4'd3);
    #2;
    capture = 1'b1;
    clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    capture = 1'b0;
    clear_overrun = 1'b0;
    @(negedge clk);
    chk("overrun_set_wins", overrun, 1);
    find_index("find9", 4'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_overrun", overrun, 0);
    exp_q.delete();
    vcnt = 0;
    repeat (4) begin
      @(negedge clk);
      vcnt += int'(drain_done);
    end
    chk("rst_no_drain_done", vcnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Recovery after reset
    set_ramp();
    issue_tile(5'd4, 1'b0);
    wait_idle("recover_timeout", 50);
    chk("recover_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
